// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus an iterative multiply/divide unit with HI/LO.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset
//   a, b   in   WIDTH-bit operands (rs, rt/immediate)
//   func   in   5-bit operation select
//   shamt  in   SHW-bit constant shift amount
//   start  in   launches MULT/MULTU/DIV/DIVU or performs an MTHI/MTLO write
//   y      out  combinational result; zero = (y == 0)
//   busy   out  multiply/divide iterating
//   done   out  one-cycle completion pulse, aligned with the new hi/lo
//   hi, lo out  HI and LO registers
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a launch
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIN   | hi/lo hold the new result, done pulse; a new launch is accepted

module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       func,
    input  logic [SHW-1:0]   shamt,
    input  logic             start,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] F_ADD   = 5'h00;
    localparam logic [4:0] F_SUB   = 5'h01;
    localparam logic [4:0] F_AND   = 5'h02;
    localparam logic [4:0] F_OR    = 5'h03;
    localparam logic [4:0] F_XOR   = 5'h04;
    localparam logic [4:0] F_SLL   = 5'h05;
    localparam logic [4:0] F_SRL   = 5'h06;
    localparam logic [4:0] F_SRA   = 5'h07;
    localparam logic [4:0] F_SLT   = 5'h08;
    localparam logic [4:0] F_SLTU  = 5'h09;
    localparam logic [4:0] F_NOR   = 5'h0A;
    localparam logic [4:0] F_SLLV  = 5'h0B;
    localparam logic [4:0] F_SRLV  = 5'h0C;
    localparam logic [4:0] F_SRAV  = 5'h0D;
    localparam logic [4:0] F_LUI   = 5'h0E;
    localparam logic [4:0] F_MULT  = 5'h10;
    localparam logic [4:0] F_MULTU = 5'h11;
    localparam logic [4:0] F_DIV   = 5'h12;
    localparam logic [4:0] F_DIVU  = 5'h13;
    localparam logic [4:0] F_MFHI  = 5'h14;
    localparam logic [4:0] F_MFLO  = 5'h15;
    localparam logic [4:0] F_MTHI  = 5'h16;
    localparam logic [4:0] F_MTLO  = 5'h17;

    localparam logic [SHW-1:0] CNT_LOAD = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;      // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic                 neg_q, neg_d;      // negate product / quotient at the end
    logic                 neg_rem_q, neg_rem_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // ---------------- combinational ALU ----------------
    always_comb begin
        y = '0;
        case (func)
            F_ADD:  y = a + b;
            F_SUB:  y = a - b;
            F_AND:  y = a & b;
            F_OR:   y = a | b;
            F_XOR:  y = a ^ b;
            F_SLL:  y = b << shamt;
            F_SRL:  y = b >> shamt;
            F_SRA:  y = $signed(b) >>> shamt;
            F_SLT:  y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            F_SLTU: y = {{(WIDTH-1){1'b0}}, a < b};
            F_NOR:  y = ~(a | b);
            F_SLLV: y = b << a[SHW-1:0];
            F_SRLV: y = b >> a[SHW-1:0];
            F_SRAV: y = $signed(b) >>> a[SHW-1:0];
            F_LUI:  y = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            F_MFHI: y = hi_q;
            F_MFLO: y = lo_q;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

    // ---------------- operand preparation ----------------
    logic             is_mul, is_div, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_mul    = (func == F_MULT) || (func == F_MULTU);
    assign is_div    = (func == F_DIV)  || (func == F_DIVU);
    assign signed_op = (func == F_MULT) || (func == F_DIV);
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, mul_fin;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo, rem;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_fin  = neg_q ? -mul_next : mul_next;

    // diff[WIDTH] set means the trial subtraction borrowed: restore.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    assign quo = div_next[WIDTH-1:0];
    assign rem = div_next[2*WIDTH-1:WIDTH];

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    if (is_mul) begin
                        state_d = MUL;
                        cnt_d   = CNT_LOAD;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        neg_d   = a_neg ^ b_neg;
                    end else if (is_div) begin
                        state_d   = DIV;
                        cnt_d     = CNT_LOAD;
                        acc_d     = {{WIDTH{1'b0}}, a_mag};
                        opnd_d    = b_mag;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        div0_d    = (b == '0);
                    end else if (func == F_MTHI) begin
                        hi_d = a;
                    end else if (func == F_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d = FIN;
                    hi_d    = mul_fin[2*WIDTH-1:WIDTH];
                    lo_d    = mul_fin[WIDTH-1:0];
                end
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d = FIN;
                    // Divisor zero: remainder path already yields |a|, sign fix restores a.
                    lo_d    = div0_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
                    hi_d    = neg_rem_q ? -rem : rem;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == MUL) || (state_q == DIV);
    assign done = (state_q == FIN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] a_in, b_in;
    logic [4:0]  func_in;
    logic [4:0]  shamt_in;
    logic        start;
    logic [31:0] y, hi, lo;
    logic        zero, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    alu_mdu #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a_in),
        .b     (b_in),
        .func  (func_in),
        .shamt (shamt_in),
        .start (start),
        .y     (y),
        .zero  (zero),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [4:0] f, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        logic [63:0] ext;
        ext = {{32{b[31]}}, b};
        case (f)
            5'h00: return a + b;
            5'h01: return a - b;
            5'h02: return a & b;
            5'h03: return a | b;
            5'h04: return a ^ b;
            5'h05: return b << sh;
            5'h06: return b >> sh;
            5'h07: return 32'(ext >> sh);
            5'h08: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5'h09: return (a < b) ? 32'd1 : 32'd0;
            5'h0A: return ~(a | b);
            5'h0B: return b << a[4:0];
            5'h0C: return b >> a[4:0];
            5'h0D: return 32'(ext >> a[4:0]);
            5'h0E: return {b[15:0], 16'h0000};
            5'h14: return model_hi;
            5'h15: return model_lo;
            default: return 32'h0;
        endcase
    endfunction

    // returns {hi, lo}
    function automatic logic [63:0] mdu_model(input logic [4:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint p;
        int     sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (f)
            5'h10: begin
                p = longint'(sa) * longint'(sb);
                return 64'(p);
            end
            5'h11: return {32'h0, a} * {32'h0, b};
            5'h12: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the next negedge.
    task automatic comb_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input string tag);
        logic [31:0] e;
        func_in  = f;
        a_in     = a;
        b_in     = b;
        shamt_in = sh;
        start    = 1'b0;
        exp_q.push_back({32'h0, alu_model(f, a, b, sh)});
        #1;
        e = 32'(exp_q.pop_front());
        check_val({tag, "_y"}, y, e);
        check_val({tag, "_zero"}, zero, (e == 32'h0));
        @(negedge clk);
    endtask

    // Called at a negedge (IDLE or FIN); returns at the done negedge.
    task automatic run_mdu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                           input int inject, input string tag);
        logic [63:0] e;
        int  nb;
        bit  got;
        func_in = f;
        a_in    = a;
        b_in    = b;
        start   = 1'b1;
        exp_q.push_back(mdu_model(f, a, b));
        @(negedge clk);
        nb  = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            start   = 1'b0;
            func_in = 5'h14;
            a_in    = $urandom;
            b_in    = $urandom;
            #1;
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) nb++;
                check_val({tag, "_hold_hi"}, hi, model_hi);
                check_val({tag, "_hold_lo"}, lo, model_lo);
                if (nb == 3) check_val({tag, "_mfhi_busy"}, y, model_hi);
                if (nb == inject) begin
                    start   = 1'b1;
                    func_in = 5'h12;
                end
                @(negedge clk);
            end
        end
        check_val({tag, "_done_seen"}, got, 1'b1);
        check_val({tag, "_busy_cycles"}, nb, 32);
        e = exp_q.pop_front();
        if (got) begin
            check_val({tag, "_hi"}, hi, e[63:32]);
            check_val({tag, "_lo"}, lo, e[31:0]);
        end
        model_hi = e[63:32];
        model_lo = e[31:0];
    endtask

    task automatic end_idle(input string tag);
        @(negedge clk);
        #1;
        check_val({tag, "_done_1cyc"}, done, 1'b0);
        check_val({tag, "_busy_after"}, busy, 1'b0);
    endtask

    task automatic move_to(input logic [4:0] f, input logic [31:0] a, input string tag);
        func_in = f;
        a_in    = a;
        start   = 1'b1;
        if (f == 5'h16) model_hi = a; else model_lo = a;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_done"}, done, 1'b0);
        check_val({tag, "_hi"}, hi, model_hi);
        check_val({tag, "_lo"}, lo, model_lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, ndone;
        reset    = 1'b1;
        a_in     = 32'h0;
        b_in     = 32'h0;
        func_in  = 5'h0;
        shamt_in = 5'h0;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_hi", hi, 32'h0);
        check_val("rst_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // First launch straight after reset release
        run_mdu(5'h11, 32'd6, 32'd7, -1, "first_multu");
        end_idle("first_multu");

        comb_op(5'h00, 32'd5, 32'd7, 5'd0, "add");
        comb_op(5'h01, 32'd5, 32'd5, 5'd0, "sub_zero");
        comb_op(5'h07, 32'd0, 32'h8000_0000, 5'd4, "sra");
        comb_op(5'h0E, 32'd0, 32'h0000_1234, 5'd0, "lui");
        comb_op(5'h00, 32'hFFFF_FFFF, 32'd1, 5'd0, "add_wrap");
        comb_op(5'h02, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, "and");
        comb_op(5'h03, 32'hF000_0000, 32'h0000_000F, 5'd0, "or");
        comb_op(5'h04, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, "xor");
        comb_op(5'h05, 32'd0, 32'h8000_0001, 5'd31, "sll");
        comb_op(5'h06, 32'd0, 32'h8000_0000, 5'd31, "srl");
        comb_op(5'h08, 32'hFFFF_FFFF, 32'd1, 5'd0, "slt");
        comb_op(5'h09, 32'hFFFF_FFFF, 32'd1, 5'd0, "sltu");
        comb_op(5'h0A, 32'h0000_FFFF, 32'hFF00_0000, 5'd0, "nor");
        comb_op(5'h0B, 32'hFFFF_FFE4, 32'h0000_0003, 5'd0, "sllv");
        comb_op(5'h0C, 32'd8, 32'h8000_0000, 5'd0, "srlv");
        comb_op(5'h0D, 32'd36, 32'h8000_0000, 5'd31, "srav");
        comb_op(5'h0F, 32'd5, 32'd7, 5'd0, "unlisted_0f");
        comb_op(5'h1F, 32'd5, 32'd7, 5'd0, "unlisted_1f");
        for (int i = 0; i < 24; i++)
            comb_op(5'($urandom_range(0, 14)), $urandom, $urandom, 5'($urandom), "rnd_comb");

        run_mdu(5'h10, 32'hFFFF_FFFE, 32'd3, -1, "mult");
        end_idle("mult");
        comb_op(5'h15, 32'd0, 32'd0, 5'd0, "mflo");
        comb_op(5'h14, 32'd0, 32'd0, 5'd0, "mfhi");

        run_mdu(5'h12, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");
        run_mdu(5'h13, 32'd7, 32'd0, -1, "divu_by0");
        run_mdu(5'h12, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        run_mdu(5'h12, 32'hFFFF_FFF9, 32'd0, -1, "div_by0_neg");
        run_mdu(5'h12, 32'd100, 32'hFFFF_FFF9, -1, "div_negdiv");
        run_mdu(5'h10, 32'h8000_0000, 32'h8000_0000, -1, "mult_minmin");
        end_idle("chain");

        // DIV pulse at busy cycle 5 must be ignored
        run_mdu(5'h11, 32'hDEAD_BEEF, 32'h1234_5678, 5, "multu_inj");
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_val("inj_extra_done", ndone, 0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : $urandom_range(1, 300);
            run_mdu(5'($urandom_range(16, 19)), ra, rb, -1, "rnd_mdu");
        end
        end_idle("rnd");

        // Reset at busy cycle 10 of MULTU aborts it
        func_in = 5'h11;
        a_in    = 32'h0001_0003;
        b_in    = 32'h0002_0005;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb    = 0;
        for (int i = 0; i < 60 && nb < 10; i++) begin
            if (busy) nb++;
            if (nb < 10) @(negedge clk);
        end
        check_val("abort_reached", nb, 10);
        reset = 1'b1;
        #1;
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_done", done, 1'b0);
        check_val("abort_hi", hi, 32'h0);
        check_val("abort_lo", lo, 32'h0);
        model_hi = 32'h0;
        model_lo = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check_val("abort_no_done", ndone, 0);
        check_val("abort_hi_after", hi, 32'h0);

        // MTHI/MTLO, then MULTU launched on the done cycle of a prior op
        move_to(5'h17, 32'h1357_9BDF, "mtlo");
        move_to(5'h16, 32'hA5A5_A5A5, "mthi");
        run_mdu(5'h13, 32'hA5A5_A5A5, 32'd0, -1, "divu_keep_hi");
        run_mdu(5'h11, 32'h0000_FFFF, 32'h0001_0001, -1, "multu_b2b");
        end_idle("b2b");

        check_val("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
